// File: rtl/isp_param_fetch.sv
// rtl/isp_param_fetch.sv - fetches primitive headers and vertices from VRAM for the ISP rasterizer
module isp_param_fetch (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        render_poly,
    input  logic [23:0] poly_addr,
    input  logic [31:0] opb_word,
    input  logic        vram_wait,
    input  logic        vram_valid,
    output logic        isp_vram_rd,
    output logic [23:0] isp_vram_addr,
    input  logic [31:0] isp_vram_din,
    output logic [31:0] isp_inst,
    output logic [31:0] tsp_inst,
    output logic [31:0] tcw_word,
    output logic [31:0] vert_a_x,
    output logic [31:0] vert_a_y,
    output logic [31:0] vert_a_z,
    output logic [31:0] vert_b_x,
    output logic [31:0] vert_b_y,
    output logic [31:0] vert_b_z,
    output logic [31:0] vert_c_x,
    output logic [31:0] vert_c_y,
    output logic [31:0] vert_c_z,
    output logic [31:0] vert_d_x,
    output logic [31:0] vert_d_y,
    output logic [31:0] vert_d_z,
    output logic        tri_quad,
    output logic        tri_odd,
    output logic        tri_valid,
    input  logic        rast_done,
    output logic        poly_drawn,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_VTX, S_EMIT, S_WAIT_RAST, S_NEXT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_wait_data;
    logic [23:0]           r_base;
    logic [3:0]            r_idx;
    logic [1:0]            r_word;
    logic [1:0]            r_vtx;
    logic [31:0]           r_isp, r_tsp, r_tcw;
    logic [3:0][2:0][31:0] r_vert;
    logic                  r_tri_odd, r_tri_quad;

    logic       w_strip, w_quad_arr, w_fetch_op, w_shadow, w_unused;
    logic [2:0] w_skip;
    logic [8:0] w_hdr_words, w_vstride, w_prim_words, w_voff, w_off;
    logic [3:0] w_vnum, w_search_start, w_next_tri;
    logic       w_found, w_fetching, w_accept, w_got, w_vtx_last, w_arr_last;

    assign w_strip      = ~opb_word[31];
    assign w_quad_arr   = (opb_word[31:29] == 3'b101);
    assign w_fetch_op   = w_strip | (opb_word[31:29] == 3'b100) | w_quad_arr;
    assign w_shadow     = opb_word[24];
    assign w_skip       = opb_word[23:21];
    assign w_unused     = ^opb_word[20:0];
    assign w_hdr_words  = w_shadow ? 9'd5 : 9'd3;
    assign w_vstride    = w_shadow ? 9'd3 + {5'd0, w_skip, 1'b0} : 9'd3 + {6'd0, w_skip};
    assign w_prim_words = w_hdr_words + (w_quad_arr ? {w_vstride[6:0], 2'b00} : 9'd3 * w_vstride);
    assign w_arr_last   = (r_idx == opb_word[28:25]);

    // Strip triangles index vertices from the shared list; array primitives restart at 0.
    assign w_vnum  = (w_strip ? r_idx : 4'd0) + {2'd0, r_vtx};
    assign w_voff  = w_hdr_words + {5'd0, w_vnum} * w_vstride + {7'd0, r_word};
    assign w_off   = (r_state == S_HDR) ? {7'd0, r_word} : w_voff;

    assign w_fetching    = (r_state == S_HDR) || (r_state == S_VTX);
    assign isp_vram_rd   = w_fetching && !r_wait_data;
    assign isp_vram_addr = isp_vram_rd ? r_base + {13'd0, w_off, 2'b00} : 24'd0;
    assign w_accept      = isp_vram_rd && !vram_wait;
    assign w_got         = r_wait_data && vram_valid;
    assign w_vtx_last    = (r_word == 2'd2) && (r_vtx == (w_quad_arr ? 2'd3 : 2'd2));

    // Lowest enabled strip triangle at or after the search start.
    assign w_search_start = (r_state == S_NEXT) ? r_idx + 4'd1 : 4'd0;
    always_comb begin
        w_found    = 1'b0;
        w_next_tri = 4'd0;
        for (int i = 5; i >= 0; i--) begin
            if (opb_word[30-i] && (4'(i) >= w_search_start)) begin
                w_found    = 1'b1;
                w_next_tri = 4'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (render_poly) w_state_nxt = w_fetch_op ? S_HDR : S_DONE;
            S_HDR:       if (w_got && r_word == 2'd2) w_state_nxt = (!w_strip || w_found) ? S_VTX : S_DONE;
            S_VTX:       if (w_got && w_vtx_last) w_state_nxt = S_EMIT;
            S_EMIT:      w_state_nxt = S_WAIT_RAST;
            S_WAIT_RAST: if (rast_done) w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (w_strip) w_state_nxt = w_found ? S_VTX : S_DONE;
                else         w_state_nxt = w_arr_last ? S_DONE : S_HDR;
            end
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_data <= 1'b0;
            r_base      <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_vtx       <= '0;
            r_isp       <= '0;
            r_tsp       <= '0;
            r_tcw       <= '0;
            r_vert      <= '0;
            r_tri_odd   <= 1'b0;
            r_tri_quad  <= 1'b0;
        end else begin
            if (w_accept)   r_wait_data <= 1'b1;
            else if (w_got) r_wait_data <= 1'b0;
            case (r_state)
                S_IDLE: if (render_poly) begin
                    r_base <= poly_addr;
                    r_idx  <= '0;
                    r_word <= '0;
                    r_vtx  <= '0;
                end
                S_HDR: if (w_got) begin
                    case (r_word)
                        2'd0:    r_isp <= isp_vram_din;
                        2'd1:    r_tsp <= isp_vram_din;
                        default: r_tcw <= isp_vram_din;
                    endcase
                    if (r_word == 2'd2) begin
                        r_word <= '0;
                        if (w_strip) r_idx <= w_next_tri;
                    end else begin
                        r_word <= r_word + 2'd1;
                    end
                end
                S_VTX: if (w_got) begin
                    r_vert[r_vtx][r_word] <= isp_vram_din;
                    if (r_word == 2'd2) begin
                        r_word <= '0;
                        if (w_vtx_last) begin
                            r_vtx      <= '0;
                            r_tri_odd  <= w_strip & r_idx[0];
                            r_tri_quad <= w_quad_arr;
                        end else begin
                            r_vtx <= r_vtx + 2'd1;
                        end
                    end else begin
                        r_word <= r_word + 2'd1;
                    end
                end
                S_NEXT: begin
                    if (w_strip) begin
                        if (w_found) r_idx <= w_next_tri;
                    end else if (!w_arr_last) begin
                        r_idx  <= r_idx + 4'd1;
                        r_base <= r_base + {13'd0, w_prim_words, 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end

    assign isp_inst   = r_isp;
    assign tsp_inst   = r_tsp;
    assign tcw_word   = r_tcw;
    assign vert_a_x   = r_vert[0][0];
    assign vert_a_y   = r_vert[0][1];
    assign vert_a_z   = r_vert[0][2];
    assign vert_b_x   = r_vert[1][0];
    assign vert_b_y   = r_vert[1][1];
    assign vert_b_z   = r_vert[1][2];
    assign vert_c_x   = r_vert[2][0];
    assign vert_c_y   = r_vert[2][1];
    assign vert_c_z   = r_vert[2][2];
    assign vert_d_x   = r_vert[3][0];
    assign vert_d_y   = r_vert[3][1];
    assign vert_d_z   = r_vert[3][2];
    assign tri_quad   = r_tri_quad;
    assign tri_odd    = r_tri_odd;
    assign tri_valid  = (r_state == S_EMIT);
    assign poly_drawn = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
endmodule
